// File: rtl/exec_issue.sv
// Execute-side issue stage: boots fetch, holds one issued instruction, turns redirects into restarts, stops on HALT.
// Optional sticky address-sequence checker enabled by defining EXEC_ISSUE_ADDR_CHECK_EN.
module exec_issue #(
   parameter int                 I_WIDTH    = 12,
   parameter int                 A_WIDTH    = 8,
   parameter logic [A_WIDTH-1:0] BOOT_ADDR  = '0,
   parameter logic [I_WIDTH-1:0] HALT_INSTR = 12'hFFF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [I_WIDTH-1:0] instruction_data_i,
   input  logic [A_WIDTH-1:0] instruction_addr_i,
   input  logic               instruction_ready_i,
   output logic               deque_o,
   output logic               restart_o,
   output logic [A_WIDTH-1:0] restart_addr_o,
   output logic               issue_valid_o,
   output logic [I_WIDTH-1:0] issue_instr_o,
   output logic [A_WIDTH-1:0] issue_addr_o,
   input  logic               issue_stall_i,
   input  logic               redirect_i,
   input  logic [A_WIDTH-1:0] redirect_addr_i,
   output logic               halted_o,
   output logic [15:0]        retired_o,
   output logic               addr_error_o
);

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_HALT     = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               valid_q, valid_d;
   logic [I_WIDTH-1:0] instr_q, instr_d;
   logic [A_WIDTH-1:0] addr_q, addr_d;
   logic [A_WIDTH-1:0] redir_q, redir_d;
   logic [15:0]        retired_q, retired_d;
   logic               deque_c;
   logic               restart_c;
   logic [A_WIDTH-1:0] restart_addr_c;
   logic               handshake;
   logic               take_redirect;

   assign handshake     = valid_q & ~issue_stall_i;
   assign take_redirect = (state_q == ST_RUN) & redirect_i;

   always_comb begin
      state_d        = state_q;
      deque_c        = 1'b0;
      restart_c      = 1'b0;
      restart_addr_c = BOOT_ADDR;
      case (state_q)
         ST_BOOT: begin
            restart_c = 1'b1;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            // A redirect squashes this cycle's dequeue; the wrong-path word is dropped.
            if (redirect_i) begin
               state_d = ST_REDIRECT;
            end else begin
               deque_c = instruction_ready_i & (~valid_q | ~issue_stall_i);
               if (deque_c && (instruction_data_i == HALT_INSTR)) state_d = ST_HALT;
            end
         end
         ST_REDIRECT: begin
            restart_c      = 1'b1;
            restart_addr_c = redir_q;
            state_d        = ST_RUN;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      valid_d   = valid_q;
      instr_d   = instr_q;
      addr_d    = addr_q;
      redir_d   = redir_q;
      retired_d = retired_q + 16'(handshake);
      if (take_redirect) begin
         valid_d = 1'b0;
         redir_d = redirect_addr_i;
      end else if (deque_c) begin
         valid_d = 1'b1;
         instr_d = instruction_data_i;
         addr_d  = instruction_addr_i;
      end else if (handshake) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_BOOT;
         valid_q   <= 1'b0;
         instr_q   <= '0;
         addr_q    <= '0;
         redir_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         addr_q    <= addr_d;
         redir_q   <= redir_d;
         retired_q <= retired_d;
      end
   end

   // The restart pulse is masked while reset is held so fetch only sees it after release.
   assign restart_o      = restart_c & rst_n;
   assign restart_addr_o = restart_addr_c;
   assign deque_o        = deque_c;
   assign issue_valid_o  = valid_q;
   assign issue_instr_o  = instr_q;
   assign issue_addr_o   = addr_q;
   assign halted_o       = (state_q == ST_HALT);
   assign retired_o      = retired_q;

`ifdef EXEC_ISSUE_ADDR_CHECK_EN
   logic [A_WIDTH-1:0] exp_addr_q, exp_addr_d;
   logic               err_q, err_d;

   always_comb begin
      exp_addr_d = exp_addr_q;
      err_d      = err_q;
      if (restart_c) begin
         exp_addr_d = restart_addr_c;
      end else if (deque_c) begin
         exp_addr_d = exp_addr_q + 1'b1;
         if (instruction_addr_i != exp_addr_q) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_addr_q <= BOOT_ADDR;
         err_q      <= 1'b0;
      end else begin
         exp_addr_q <= exp_addr_d;
         err_q      <= err_d;
      end
   end

   assign addr_error_o = err_q;
`else
   assign addr_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_exec_issue.sv
// Bench for exec_issue: behavioural fetch model, expected-issue queue with a decoupled monitor, directed checks.
module tb_exec_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] instruction_data_i;
   logic [7:0]  instruction_addr_i;
   logic        instruction_ready_i;
   logic        deque_o;
   logic        restart_o;
   logic [7:0]  restart_addr_o;
   logic        issue_valid_o;
   logic [11:0] issue_instr_o;
   logic [7:0]  issue_addr_o;
   logic        issue_stall_i;
   logic        redirect_i;
   logic [7:0]  redirect_addr_i;
   logic        halted_o;
   logic [15:0] retired_o;
   logic        addr_error_o;

   exec_issue dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .instruction_data_i  (instruction_data_i),
      .instruction_addr_i  (instruction_addr_i),
      .instruction_ready_i (instruction_ready_i),
      .deque_o             (deque_o),
      .restart_o           (restart_o),
      .restart_addr_o      (restart_addr_o),
      .issue_valid_o       (issue_valid_o),
      .issue_instr_o       (issue_instr_o),
      .issue_addr_o        (issue_addr_o),
      .issue_stall_i       (issue_stall_i),
      .redirect_i          (redirect_i),
      .redirect_addr_i     (redirect_addr_i),
      .halted_o            (halted_o),
      .retired_o           (retired_o),
      .addr_error_o        (addr_error_o)
   );

   // clock
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [19:0] exp_q[$];
   logic [15:0] ret_model = '0;

   // fetch model state
   logic [7:0]  pc = '0;
   logic        halt_en = 1'b0;
   logic [7:0]  halt_pc = '0;
   logic        skip = 1'b0;
   logic        d_s, r_s;
   logic [7:0]  ra_s;
   logic [15:0] wrap_k;
   logic        exp_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive_fetch();
      instruction_addr_i = pc + ((skip && pc >= 8'd2) ? 8'd1 : 8'd0);
      instruction_data_i = (halt_en && pc == halt_pc) ? 12'hFFF : {4'h5, pc};
   endtask

   // Mid-cycle sample: record what the DUT asks of fetch and queue any dequeued word.
   task automatic sample();
      @(negedge clk);
      d_s  = deque_o;
      r_s  = restart_o;
      ra_s = restart_addr_o;
      if (d_s === 1'b1) exp_q.push_back({instruction_data_i, instruction_addr_i});
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (r_s === 1'b1) pc = ra_s;
      else if (d_s === 1'b1) pc = pc + 8'd1;
      drive_fetch();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         sample();
         advance();
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         exp_q.delete();
         ret_model = '0;
      end else begin
         check("retired_track", retired_o, ret_model);
         if (issue_valid_o === 1'b1 && issue_stall_i === 1'b0) begin
            if (exp_q.size() == 0) check("issue_unexpected", exp_q.size(), 1);
            else check("issue_word", {issue_instr_o, issue_addr_o}, exp_q.pop_front());
            ret_model = ret_model + 16'd1;
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      instruction_ready_i = 1'b0;
      issue_stall_i = 1'b0;
      redirect_i = 1'b0;
      redirect_addr_i = '0;
      drive_fetch();

      // reset state
      run(3);
      sample();
      check("rst_valid", issue_valid_o, 0);
      check("rst_retired", retired_o, 0);
      check("rst_halted", halted_o, 0);
      check("rst_restart", restart_o, 0);
      check("rst_restart_addr", restart_addr_o, 8'h00);
      check("rst_addr_error", addr_error_o, 0);
      check("rst_deque", deque_o, 0);
      advance();

      // boot and streaming
      rst_n = 1'b1;
      instruction_ready_i = 1'b1;
      sample();
      check("boot_restart", r_s, 1);
      check("boot_restart_addr", ra_s, 8'h00);
      check("boot_deque", d_s, 0);
      advance();
      sample();
      check("first_deque", d_s, 1);
      check("restart_not_twice", r_s, 0);
      advance();
      sample();
      check("stream_valid", issue_valid_o, 1);
      check("stream_addr0", issue_addr_o, 8'h00);
      advance();
      sample();
      check("stream_addr1", issue_addr_o, 8'h01);
      check("stream_ret1", retired_o, 1);
      advance();
      sample();
      check("stream_addr2", issue_addr_o, 8'h02);
      check("stream_ret2", retired_o, 2);
      advance();

      // stall for three cycles
      issue_stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("stall_deque", d_s, 0);
         check("stall_hold_addr", issue_addr_o, 8'h03);
         check("stall_hold_valid", issue_valid_o, 1);
         advance();
      end
      issue_stall_i = 1'b0;
      sample();
      check("unstall_deque", d_s, 1);
      check("unstall_addr", issue_addr_o, 8'h03);
      advance();
      sample();
      check("post_stall_addr", issue_addr_o, 8'h04);
      advance();

      // redirect to 0x40
      redirect_i = 1'b1;
      redirect_addr_i = 8'h40;
      sample();
      check("redir_deque", d_s, 0);
      advance();
      redirect_i = 1'b0;
      redirect_addr_i = 8'h00;
      sample();
      check("redir_restart", r_s, 1);
      check("redir_restart_addr", ra_s, 8'h40);
      check("redir_valid", issue_valid_o, 0);
      check("redir_deque_blocked", d_s, 0);
      advance();
      sample();
      check("redir_first_deque", d_s, 1);
      check("redir_restart_once", r_s, 0);
      advance();
      sample();
      check("redir_issue_addr", issue_addr_o, 8'h40);
      advance();
      instruction_ready_i = 1'b0;
      run(3);

      // retired counter wrap: fill up to 0xFFFE, then two more
      wrap_k = 16'hFFFE - ret_model;
      instruction_ready_i = 1'b1;
      run(int'(wrap_k));
      instruction_ready_i = 1'b0;
      run(3);
      check("retired_fffe", retired_o, 16'hFFFE);
      instruction_ready_i = 1'b1;
      run(2);
      instruction_ready_i = 1'b0;
      run(3);
      check("retired_wrap", retired_o, 16'h0000);

      // HALT at 0x05, reached via a redirect to 0x03
      halt_en = 1'b1;
      halt_pc = 8'h05;
      redirect_i = 1'b1;
      redirect_addr_i = 8'h03;
      run(1);
      redirect_i = 1'b0;
      instruction_ready_i = 1'b1;
      sample();
      check("halt_path_restart_addr", ra_s, 8'h03);
      advance();
      run(3);
      redirect_i = 1'b1;
      redirect_addr_i = 8'h80;
      sample();
      check("halt_halted", halted_o, 1);
      check("halt_deque", d_s, 0);
      check("halt_instr", issue_instr_o, 12'hFFF);
      check("halt_addr", issue_addr_o, 8'h05);
      advance();
      redirect_i = 1'b0;
      sample();
      check("halt_ignore_redirect", r_s, 0);
      check("halt_deque_still0", d_s, 0);
      check("halt_still", halted_o, 1);
      check("halt_drained", issue_valid_o, 0);
      check("halt_retired", retired_o, 3);
      check("queue_empty", exp_q.size(), 0);
      advance();

      rst_n = 1'b0;
      instruction_ready_i = 1'b0;
      halt_en = 1'b0;
      run(2);
      sample();
      check("rst2_halted", halted_o, 0);
      check("rst2_valid", issue_valid_o, 0);
      advance();

      // address sequence 0,1,3: sticky error only when the checker is built in
`ifdef EXEC_ISSUE_ADDR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      skip = 1'b1;
      rst_n = 1'b1;
      instruction_ready_i = 1'b1;
      run(4);
      sample();
      check("addr_err_set", addr_error_o, exp_err);
      advance();
      instruction_ready_i = 1'b0;
      run(3);
      sample();
      check("addr_err_sticky", addr_error_o, exp_err);
      advance();
      rst_n = 1'b0;
      run(2);
      sample();
      check("addr_err_cleared", addr_error_o, 0);
      advance();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
